sub16_serial: RTL and testbench
===============================

// Module: sub16_serial
// PURPOSE
//   Multi-cycle sliced subtractor: result = operand1 - operand2 - bin, computed
//   SLICE bits per cycle, LSB slice first, with the borrow registered between slices.
//   It is the subtract counterpart of the combinational 16-bit adder in the ALU datapath.
//   It trades latency for a short carry chain.
//   A valid/ready handshake on both sides lets the control unit stall or accept the result.
// PARAMETERS
//   WIDTH  16  operand/result width in bits
//   SLICE   4  bits processed per CALC cycle; WIDTH % SLICE must be 0 (elaboration error otherwise)
// PORTS
//   clk        in   1      rising-edge clock
//   resetn     in   1      asynchronous, active-low reset
//   in_valid   in   1      operands/bin valid
//   in_ready   out  1      block can accept operands
//   operand1   in   WIDTH  minuend
//   operand2   in   WIDTH  subtrahend
//   bin        in   1      borrow in
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  operand1 - operand2 - bin, modulo 2^WIDTH
//   bout       out  1      borrow out: 1 iff unsigned operand1 < operand2 + bin
//   ovf        out  1      signed overflow: op1[MSB]!=op2[MSB] && result[MSB]!=op1[MSB]
//   zero       out  1      result == 0
// BEHAVIOUR
//   - Reset (resetn=0, async): state=IDLE, in_ready=1, out_valid=0.
//     Reset also clears result, bout, ovf, zero and the slice counter to 0.
//     Reset mid-CALC or mid-DONE aborts the operation; no output handshake occurs.
//   - FSM IDLE -> CALC -> DONE -> IDLE. N = WIDTH/SLICE slices.
//   - IDLE: in_ready=1. On in_valid&&in_ready at edge k:
//     - latch operand1, operand2, bin; borrow register <= bin;
//     - slice counter <= 0; go CALC.
//   - CALC: in_ready=0. Each cycle handles slice i = counter:
//     - {b, r} = op1[i] - op2[i] - borrow;
//     - result[i] <= r; borrow <= b; counter++.
//     - After slice N-1 (edge k+N): go DONE; out_valid=1.
//     - bout is the final borrow; ovf and zero are taken from the full result.
//   - Latency: out_valid rises N cycles after the accept edge (4 cycles at defaults).
//   - DONE: out_valid=1, in_ready=0. result/bout/ovf/zero are held stable until
//     out_valid&&out_ready, then go IDLE with out_valid=0 on the next edge.
//     - No overlap: the next accept happens no earlier than the cycle after the output handshake.
//   - in_valid in CALC/DONE is ignored; operands are not re-sampled.
//   - out_ready outside DONE has no effect.
//   - Outputs are unchanged from the previous operation while in IDLE/CALC; they are valid only with out_valid.
//   - Arithmetic is exact modulo 2^WIDTH. Internally, subtraction is
//     op1 + ~op2 + ~bin per slice with borrow = ~carry; both forms are equivalent.
// TESTING
//   1 op1=0x1234 op2=0x0034 bin=0 -> result=0x1200 bout=0 ovf=0 zero=0; out_valid exactly 4 cycles after accept
//   2 op1=0x0000 op2=0x0001 bin=0 -> result=0xFFFF bout=1 ovf=0 zero=0 (borrow through all slices)
//   3 op1=0x8000 op2=0x0001 bin=0 -> result=0x7FFF bout=0 ovf=1; op1=0x7FFF op2=0xFFFF -> 0x8000 bout=1 ovf=1
//   4 op1=op2=0x5555 bin=0 -> result=0x0000 zero=1 bout=0; same with bin=1 -> 0xFFFF bout=1 zero=0
//   5 out_ready=0 for 3 cycles in DONE -> out_valid and outputs held, in_ready=0; in_valid pulses ignored; accept only after handshake
//   6 resetn=0 for 1 cycle during 2nd CALC cycle -> IDLE, out_valid=0, in_ready=1, outputs 0; new op 0x0010-0x0001 -> 0x000F

Source files
------------

// File: rtl/sub16_serial_if.sv
// Handshake and operand/result bundle for the sliced subtractor.
// master: the control unit driving operands and consuming the result.
// slave:  the subtractor itself.
interface sub16_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, operand1, operand2, bin, out_ready,
    input  in_ready, out_valid, result, bout, ovf, zero
  );

  modport slave (
    input  in_valid, operand1, operand2, bin, out_ready,
    output in_ready, out_valid, result, bout, ovf, zero
  );
endinterface

// File: rtl/sub16_serial.sv
// Multi-cycle sliced subtractor: result = operand1 - operand2 - bin.
// SLICE bits are handled per cycle, LSB slice first, with the borrow
// registered between slices to keep the carry chain short. Published
// result/flags only change when the last slice completes, so they stay
// at the previous operation's values while a new one is in flight.
module sub16_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic           clk,
  input  logic           resetn,
  sub16_serial_if.slave  bus
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((WIDTH % SLICE) != 0) begin : g_width_check
    $error("sub16_serial: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // One slice of op1 - op2 - borrow, done as op1 + ~op2 + ~borrow.
  // Returns {borrow_out, difference}; borrow_out is the inverted carry.
  function automatic logic [SLICE:0] sub_slice(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             bi);
    logic [SLICE:0] s;
    s = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, ~bi};
    return {~s[SLICE], s[SLICE-1:0]};
  endfunction

  // Two's-complement overflow of a - b: operand signs differ and the
  // result sign disagrees with the minuend.
  function automatic logic ovf_flag(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic             in_ready;
  logic             out_valid;

  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic [WIDTH-1:0] acc;
  logic             borrow;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] result_q;
  logic             bout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] r_s;
  logic             bo_s;
  logic [WIDTH-1:0] acc_nxt;
  logic             last;

  // Select the current slice, subtract it and merge it into the accumulator.
  always_comb begin
    a_s     = op1_q[cnt*SLICE +: SLICE];
    b_s     = op2_q[cnt*SLICE +: SLICE];
    {bo_s, r_s} = sub_slice(a_s, b_s, borrow);
    acc_nxt = acc;
    acc_nxt[cnt*SLICE +: SLICE] = r_s;
    last    = (cnt == LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, slice iteration and publication of result/flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op1_q    <= '0;
      op2_q    <= '0;
      acc      <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op1_q  <= bus.operand1;
            op2_q  <= bus.operand2;
            borrow <= bus.bin;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          borrow <= bo_s;
          cnt    <= last ? '0 : cnt + CNT_W'(1);
          if (last) begin
            result_q <= acc_nxt;
            bout_q   <= bo_s;
            ovf_q    <= ovf_flag(op1_q, op2_q, acc_nxt);
            zero_q   <= (acc_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_sub16_serial.sv
// Scoreboard bench for sub16_serial: expected results are computed from a
// 17-bit reference subtraction when operands are accepted, queued, and
// compared when the DUT presents out_valid.
module tb_sub16_serial;

  typedef struct packed {
    logic [15:0] result;
    logic        bout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;
  exp_t sb[$];
  logic [15:0] last_res;

  sub16_serial_if #(.WIDTH(16)) bus ();

  sub16_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t e;
    logic [16:0] d;
    d = {1'b0, a} - {1'b0, b} - {16'd0, c};
    e.result = d[15:0];
    e.bout   = d[16];
    e.ovf    = (a[15] != b[15]) && (d[15] != a[15]);
    e.zero   = (d[15:0] == 16'd0);
    return e;
  endfunction

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".result"}, {16'd0, bus.result}, {16'd0, e.result});
    chk({tag, ".bout"},   {31'd0, bus.bout},   {31'd0, e.bout});
    chk({tag, ".ovf"},    {31'd0, bus.ovf},    {31'd0, e.ovf});
    chk({tag, ".zero"},   {31'd0, bus.zero},   {31'd0, e.zero});
  endtask

  // Accept one operation, check latency, optionally stall the consumer for
  // 'stall' cycles while pulsing in_valid, then complete the handshake.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic c, input int stall);
    int   lat;
    exp_t e;
    @(negedge clk);
    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.operand1 = a;
    bus.operand2 = b;
    bus.bin      = c;
    @(posedge clk);
    sb.push_back(model(a, b, c));
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.operand1  = ~a;
    bus.operand2  = ~b;
    bus.out_ready = (stall == 0);
    chk("in_ready_calc", {31'd0, bus.in_ready}, 32'd0);
    chk("result_held_calc", {16'd0, bus.result}, {16'd0, last_res});
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, 32'd4);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb[0];
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'b1;
      bus.operand1 = 16'hDEAD;
      bus.operand2 = 16'h0001;
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk_out("stall", e);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk_out("out", e);
    void'(sb.pop_front());
    last_res = e.result;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_after_hs", {31'd0, bus.out_valid}, 32'd0);
    chk("in_ready_after_hs",  {31'd0, bus.in_ready},  32'd1);
    chk_out("hold_idle", e);
  endtask

  initial begin
    int quiet;
    n_vec = 0;
    n_err = 0;
    last_res      = 16'd0;
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.operand1  = 16'd0;
    bus.operand2  = 16'd0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_result",    {16'd0, bus.result},    32'd0);
    resetn = 1'b1;

    run_op(16'h1234, 16'h0034, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
    run_op(16'h5555, 16'h5555, 1'b0, 0);
    run_op(16'h5555, 16'h5555, 1'b1, 0);
    run_op(16'h0000, 16'hFFFF, 1'b1, 0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 3);

    // Reset asserted during the second CALC cycle aborts the operation.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.operand1 = 16'h0F0F;
    bus.operand2 = 16'h0101;
    bus.bin      = 1'b0;
    @(posedge clk);
    sb.push_back(model(16'h0F0F, 16'h0101, 1'b0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("arst_result",    {16'd0, bus.result},    32'd0);
    chk("arst_bout",      {31'd0, bus.bout},      32'd0);
    chk("arst_ovf",       {31'd0, bus.ovf},       32'd0);
    chk("arst_zero",      {31'd0, bus.zero},      32'd0);
    @(negedge clk);
    resetn = 1'b1;
    sb.delete();
    last_res = 16'd0;
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) quiet++;
    end
    chk("arst_no_output", quiet, 32'd0);
    run_op(16'h0010, 16'h0001, 1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
